led_bank_arbiter: RTL

Shares the board's 8-bit LED bank between two requesters, such as the SPART driver status path and a debug source. Each granted pattern stays on the LEDs for a programmable hold time. The block rotates priority between requesters. When no request is being served, it drives an idle heartbeat. It sits between the requesting logic and the `LEDs_8Bit` pins in the top level.

---
 rtl/led_bank_arbiter.sv | 105 ++++++++++
 1 files changed

// File: rtl/led_bank_arbiter.sv
// led_bank_arbiter: shares an 8-bit LED bank between two requesters.
// Each grant is shown for a fixed hold time. Priority rotates, and an
// idle heartbeat is shown when no request is being served.
//   clk, rst       : clock, async active-high reset
//   req[1:0]       : level requests, dropped by requester on gnt
//   pat0, pat1     : patterns, sampled only at the grant edge
//   gnt[1:0]       : one-cycle one-hot grant pulse
//   busy           : high while a granted pattern is displayed
//   LEDs_8Bit[7:0] : registered LED drive
module led_bank_arbiter #(
    parameter int TICK_DIV   = 100000,
    parameter int HOLD_TICKS = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [7:0] pat0,
    input  logic [7:0] pat1,
    output logic [1:0] gnt,
    output logic       busy,
    output logic [7:0] LEDs_8Bit
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam logic [PW-1:0] PMAX  = PW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HLOAD = HW'(HOLD_TICKS);
    localparam logic [7:0]    HB_A  = 8'hAA;

    typedef enum logic {IDLE, SHOW} state_t;

    state_t      state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [HW-1:0] hold_q, hold_d;
    logic        last_q, last_d;
    logic [7:0]  led_q, led_d;
    logic [1:0]  gnt_q, gnt_d;

    logic tick;
    logic hold_one;
    logic expire;
    logic grant;
    logic win;

    assign tick     = (presc_q == PMAX);
    assign hold_one = (hold_q == HW'(1));
    assign expire   = (state_q == SHOW) && tick && hold_one;
    // Arbitration happens whenever idle, or at the end of a slot.
    assign grant    = ((state_q == IDLE) || expire) && (|req);
    // On a tie the requester not granted last time wins.
    assign win      = (req[1] && req[0]) ? ~last_q : req[1];

    always_comb begin
        state_d = state_q;
        presc_d = tick ? '0 : presc_q + PW'(1);
        hold_d  = hold_q;
        last_d  = last_q;
        led_d   = led_q;
        gnt_d   = 2'b00;
        if (grant) begin
            // Restart the prescaler so the slot length is exact.
            state_d = SHOW;
            presc_d = '0;
            hold_d  = HLOAD;
            last_d  = win;
            gnt_d   = win ? 2'b10 : 2'b01;
            led_d   = win ? pat1 : pat0;
        end else if (expire) begin
            state_d = IDLE;
            presc_d = '0;
            hold_d  = HLOAD;
            led_d   = HB_A;
        end else if (tick) begin
            if ((state_q == IDLE) && hold_one) begin
                led_d  = ~led_q;
                hold_d = HLOAD;
            end else begin
                hold_d = hold_q - HW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            presc_q <= '0;
            hold_q  <= HLOAD;
            last_q  <= 1'b1;
            led_q   <= HB_A;
            gnt_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
            led_q   <= led_d;
            gnt_q   <= gnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign busy      = (state_q == SHOW);
    assign LEDs_8Bit = led_q;

endmodule
